// File: rtl/lns_to_lin_pkg.sv
// Shared constants and types for the LNS-to-linear output converter.
// Defaults match the lns_mac output word (OUT_BITS+1 bit log, 8 fractional bits).
package lns_to_lin_pkg;

    localparam int OUT_BITS      = 15;
    localparam int LOG_W_DEF     = OUT_BITS + 1;
    localparam int LOG_FRAC_DEF  = 8;
    localparam int LIN_W_DEF     = 32;
    localparam int LIN_FRAC_DEF  = 8;
    localparam int MANT_FRAC_DEF = 16;

    // Most-negative log code stands for an exact linear zero.
    localparam logic [LOG_W_DEF-1:0] ZERO_CODE = {1'b1, {(LOG_W_DEF-1){1'b0}}};

    typedef logic signed [LIN_W_DEF-1:0] lin_t;

endpackage

// File: rtl/lns_pow2_lut.sv
// Combinational mantissa table: frac -> round(2^(frac/2^LOG_FRAC) * 2^MANT_FRAC).
// The table contents are generated at elaboration time from the exact formula.
module lns_pow2_lut
    import lns_to_lin_pkg::*;
#(
    parameter int LOG_FRAC  = LOG_FRAC_DEF,
    parameter int MANT_FRAC = MANT_FRAC_DEF
) (
    input  logic [LOG_FRAC-1:0]  frac,
    output logic [MANT_FRAC:0]   mant
);

    logic [MANT_FRAC:0] rom [2**LOG_FRAC];

    for (genvar g = 0; g < 2**LOG_FRAC; g++) begin : g_rom
        localparam real EXPO = real'(g) / real'(2**LOG_FRAC);
        localparam int  MVAL = $rtoi((2.0 ** EXPO) * (2.0 ** MANT_FRAC) + 0.5);
        assign rom[g] = (MANT_FRAC+1)'(MVAL);
    end

    assign mant = rom[frac];

endmodule

// File: rtl/lns_to_lin.sv
// Three-stage stallable converter from signed LNS word + natural sign to
// two's-complement linear fixed point (lookup, shift/saturate, sign).
module lns_to_lin
    import lns_to_lin_pkg::*;
#(
    parameter int LOG_W     = LOG_W_DEF,
    parameter int LOG_FRAC  = LOG_FRAC_DEF,
    parameter int LIN_W     = LIN_W_DEF,
    parameter int LIN_FRAC  = LIN_FRAC_DEF,
    parameter int MANT_FRAC = MANT_FRAC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_in_valid,
    output logic                    data_in_enable,
    input  logic [LOG_W-1:0]        data_in_log,
    input  logic                    data_in_nat_sign,
    output logic                    data_out_valid,
    input  logic                    data_out_enable,
    output logic signed [LIN_W-1:0] data_out_lin
);

    localparam int IW    = LOG_W - LOG_FRAC;
    localparam int SAT_I = LIN_W - 2 - LIN_FRAC;
    localparam logic [LOG_W-1:0] ZCODE   = {1'b1, {(LOG_W-1){1'b0}}};
    localparam logic [LIN_W-1:0] SAT_MAG = {1'b0, {(LIN_W-1){1'b1}}};

    logic stall;
    logic adv;

    assign stall          = data_out_valid & ~data_out_enable;
    assign adv            = ~stall;
    assign data_in_enable = rst | adv;

    logic [MANT_FRAC:0] lut_mant;

    lns_pow2_lut #(
        .LOG_FRAC  (LOG_FRAC),
        .MANT_FRAC (MANT_FRAC)
    ) u_lut (
        .frac (data_in_log[LOG_FRAC-1:0]),
        .mant (lut_mant)
    );

    logic                 s1_valid;
    logic [MANT_FRAC:0]   s1_mant;
    logic signed [IW-1:0] s1_int;
    logic                 s1_pos;
    logic                 s1_zero;

    logic                 s2_valid;
    logic [LIN_W-1:0]     s2_mag;
    logic                 s2_pos;

    int               shamt;
    logic [LIN_W-1:0] mant_ext;
    logic [LIN_W-1:0] mag_d;

    // Right shifts round half up; anything below half an LSB after the
    // widest useful shift collapses to zero.
    always_comb begin
        shamt    = int'(s1_int) + LIN_FRAC - MANT_FRAC;
        mant_ext = LIN_W'(s1_mant);
        mag_d    = '0;
        if (s1_zero) begin
            mag_d = '0;
        end else if (int'(s1_int) > SAT_I) begin
            mag_d = SAT_MAG;
        end else if (shamt >= 0) begin
            mag_d = mant_ext << shamt;
        end else if (shamt >= -(MANT_FRAC + 1)) begin
            mag_d = (mant_ext + (LIN_W'(1) << (-shamt - 1))) >> (-shamt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_mant        <= '0;
            s1_int         <= '0;
            s1_pos         <= 1'b0;
            s1_zero        <= 1'b0;
            s2_valid       <= 1'b0;
            s2_mag         <= '0;
            s2_pos         <= 1'b0;
            data_out_valid <= 1'b0;
            data_out_lin   <= '0;
        end else if (adv) begin
            s1_valid       <= data_in_valid;
            s2_valid       <= s1_valid;
            data_out_valid <= s2_valid;
            if (data_in_valid) begin
                s1_mant <= lut_mant;
                s1_int  <= data_in_log[LOG_W-1:LOG_FRAC];
                s1_pos  <= data_in_nat_sign;
                s1_zero <= (data_in_log == ZCODE);
            end
            if (s1_valid) begin
                s2_mag <= mag_d;
                s2_pos <= s1_pos;
            end
            if (s2_valid) begin
                data_out_lin <= s2_pos ? s2_mag : -s2_mag;
            end
        end
    end

endmodule

// File: tb/tb_lns_to_lin.sv
// Scoreboard bench for lns_to_lin: directed spec vectors, back-pressure,
// mid-stream reset and randomized traffic against a real-arithmetic model.
module tb_lns_to_lin;
    import lns_to_lin_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_enable;
    logic [15:0]        in_log = '0;
    logic               in_sign = 1'b1;
    logic               out_valid;
    logic               out_enable = 1'b1;
    logic signed [31:0] out_lin;

    always #5 clk = ~clk;

    lns_to_lin dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_valid    (in_valid),
        .data_in_enable   (in_enable),
        .data_in_log      (in_log),
        .data_in_nat_sign (in_sign),
        .data_out_valid   (out_valid),
        .data_out_enable  (out_enable),
        .data_out_lin     (out_lin)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_lin = '0;
    bit          rnd_done = 1'b0;

    // Value = 2^(log/256) in units of 2^-8, rounded half up, symmetric saturation.
    function automatic logic [31:0] ref_lin(input logic [15:0] lg, input logic pos);
        int  i;
        int  f;
        real m;
        real v;
        int  mag;
        if (lg == ZERO_CODE) return 32'd0;
        i = int'($signed(lg[15:8]));
        f = int'(lg[7:0]);
        m = $floor((2.0 ** (f / 256.0)) * 65536.0 + 0.5);
        if (i > 22) begin
            mag = 32'h7FFF_FFFF;
        end else begin
            v   = m * (2.0 ** (i - 16 + 8));
            mag = $rtoi($floor(v + 0.5));
        end
        return pos ? 32'(mag) : 32'(-mag);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: handshake rule, hold-while-stalled, and in-order scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_enable", 32'(in_enable), 32'(!(out_valid && !out_enable)));
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_lin, prev_lin);
            end
            if (out_valid && out_enable) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %h expected none", out_lin);
                end else begin
                    check("data", out_lin, exp_q.pop_front());
                end
            end
            if (in_valid && in_enable) exp_q.push_back(ref_lin(in_log, in_sign));
            prev_stall = out_valid && !out_enable;
            prev_lin   = out_lin;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic [15:0] lg, input logic sg);
        bit ok;
        ok       = 1'b0;
        in_log   = lg;
        in_sign  = sg;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_enable) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    logic [15:0] d_log[10] = '{16'h0000, 16'h0100, 16'h0080, 16'h0100, 16'h8000,
                               16'h8000, 16'h1800, 16'h1800, 16'h1600, 16'hF000};
    logic        d_pos[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] d_exp[10] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_016A, 32'hFFFF_FE00,
                               32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0001,
                               32'h4000_0000, 32'h0000_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_lin", out_lin, 32'd0);
        check("rst_in_enable", 32'(in_enable), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors, one at a time, exact 3-cycle latency.
        for (int k = 0; k < 10; k++) begin
            send(d_log[k], d_pos[k]);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c < 3) begin
                    check("lat_early", 32'(out_valid), 32'd0);
                end else begin
                    check("lat_valid", 32'(out_valid), 32'd1);
                    check("directed", out_lin, d_exp[k]);
                end
            end
            @(posedge clk);
            #1;
        end

        // Back-pressure: five words, output blocked, then released.
        out_enable = 1'b0;
        send(16'h0000, 1'b1);
        send(16'h0100, 1'b0);
        send(16'h0080, 1'b1);
        @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_enable", 32'(in_enable), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        fork
            begin
                send(16'h0200, 1'b1);
                send(16'hFF80, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_enable = 1'b1;
            end
        join
        drain();

        // Reset with three words in flight; none may ever appear.
        send(16'h0300, 1'b1);
        send(16'h0400, 1'b0);
        in_log   = 16'h0500;
        in_sign  = 1'b1;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_flush_valid", 32'(out_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        send(16'h0100, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) check("post_rst_early", 32'(out_valid), 32'd0);
            else check("post_rst_lin", out_lin, 32'h0000_0200);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure.
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_enable = ($urandom_range(0, 9) < 7);
                end
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    int          ii;
                    logic [15:0] lg;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(0, 3))
                        0: lg = 16'($urandom);
                        1: begin
                            ii = int'($urandom_range(0, 47)) - 22;
                            lg = {ii[7:0], 8'($urandom_range(0, 255))};
                        end
                        2: lg = ZERO_CODE;
                        default: lg = {8'($urandom_range(20, 26)), 8'($urandom_range(0, 255))};
                    endcase
                    send(lg, 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
        join
        #1 out_enable = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lns_to_lin.md
# lns_to_lin

Converts the signed log-domain (LNS) accumulator word and natural sign produced by `lns_mac` back into a two's-complement linear fixed-point value. It sits on the output side of the MAC and consumes the MAC's `data_out_valid`/`data_out_enable` handshake as its input. It is a 3-stage stallable pipeline with the same valid/enable handshake on its output, feeding the linear result bus.

## Interface

Parameters:
- `LOG_W`, default `OUT_BITS+1` (16): width of the log input word, signed.
- `LOG_FRAC`, default 8: fractional bits of the log word.
- `LIN_W`, default 32: width of the linear output, signed.
- `LIN_FRAC`, default 8: fractional bits of the linear output.
- `MANT_FRAC`, default 16: fractional bits of the 2^f mantissa in the LUT.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in_valid`  in  1  input word present.
- `data_in_enable`  out  1  block can accept the input this cycle.
- `data_in_log`  in  LOG_W  signed log2 magnitude.
- `data_in_nat_sign`  in  1  natural sign: 1 means positive, 0 means negative (MAC convention).
- `data_out_valid`  out  1  `data_out_lin` holds a result.
- `data_out_enable`  in  1  downstream accepts the result.
- `data_out_lin`  out  LIN_W  signed linear result.

## Operation

- Transfer rule: a word is taken when `data_in_valid & data_in_enable`. A result is consumed when `data_out_valid & data_out_enable`.
- Split the log word into i = `data_in_log[LOG_W-1:LOG_FRAC]` (signed) and f = `data_in_log[LOG_FRAC-1:0]`.
- Zero code: `data_in_log` = most-negative value (0x8000) means exact zero and produces `data_out_lin` = 0.
- S1 (lookup): M = round(2^(f/2^LOG_FRAC) · 2^MANT_FRAC). M is MANT_FRAC+1 bits wide, 65536..131071. Register M, i, sign and the zero flag.
- S2 (shift): s = i + LIN_FRAC − MANT_FRAC.
  - s ≥ 0: M << s.
  - s < 0: (M + 2^(−s−1)) >> −s, i.e. round half up.
  - s < −(MANT_FRAC+1): result 0.
  - i > LIN_W−2−LIN_FRAC (i ≥ 23 at defaults): saturate magnitude to 2^(LIN_W−1)−1.
- S3 (sign): when nat_sign = 0, output the two's-complement negation. Saturation is symmetric, so the negative limit is 0x80000001. Zero stays 0 regardless of sign.

## Timing

- Latency is 3 cycles from input transfer to `data_out_valid`, with no stall. Throughput is one word per cycle.
- `stall = data_out_valid & ~data_out_enable`. On stall all stages hold. `data_in_enable = ~stall` (combinational).
- Per-stage valid bits advance when ~stall. Pipeline bubbles propagate as invalid stages.
- Reset values: all stage valids 0, `data_out_valid` 0, `data_out_lin` 0. `data_in_enable` is 1 during and after reset.
- `rst` asserted mid-stream discards all in-flight words. The cycle after deassertion behaves like the first cycle after power-up.
- Input and output transfers in the same cycle are legal and lose nothing.
- Data registers update only on an advancing valid stage. Held output data is stable while stalled.

## Structure

- Add to `lns_mac_pkg`:
  - default constants `LOG_FRAC`, `LIN_W`, `LIN_FRAC`, `MANT_FRAC`;
  - `ZERO_CODE`;
  - a `lin_t` typedef.
- The mantissa LUT is a generated include file, `Pow2LUT8bit.txt`, of `case` items in the same style as the Gauss LUTs. Wrap it in sub-module `lns_pow2_lut` (combinational, f → M).
- The pipeline, shifter, saturation and handshake stay in `lns_to_lin`. Expected size is about 200 lines.

## Test plan

- 0x0000, sign 1 → 0x00000100 (1.0). 0x0100, sign 1 → 0x00000200. 0x0080, sign 1 → 0x0000016A (√2 rounded). Each appears exactly 3 cycles after its input transfer.
- 0x0100, sign 0 → 0xFFFFFE00. Zero code 0x8000 with either sign → 0x00000000.
- Saturation and underflow:
  - 0x1800, sign 1 → 0x7FFFFFFF.
  - 0x1800, sign 0 → 0x80000001.
  - 0x1600 (i = 22) → 0x40000000.
  - 0xF000 (i = −16) → 0.
- Back-pressure:
  - Stream 5 words with `data_out_enable` low from cycle 4. Then `data_in_enable` drops in the same cycle that `data_out_valid` rises, and the output holds.
  - Releasing the enable drains the words in order with no loss or duplicates.
- Assert `rst` for one cycle with 3 words in flight → `data_out_valid` 0 the next cycle and those words never appear. A new word afterwards emerges after 3 cycles.
- End-to-end: drive `lns_mac` → `lns_to_lin` with x = y = 0x0080 (both positive) after `clr`. The MAC accumulates 2.0 in log, 0x0100, and the converter must output 0x00000200.
